uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter ADDR_W, default 16, address width in bits; SHALL be a multiple of 4, giving ADDR_W/4 max hex digits.
REQ-002 Parameter DATA_W, default 16, write-data width in bits; SHALL be a multiple of 4, giving DATA_W/4 max hex digits.
REQ-003 MCLK  in  1  single clock for the whole block.
REQ-004 HRST  in  1  reset, synchronous to MCLK, active-high.
REQ-005 i_DATA  in  8  received byte from the UART receiver.
REQ-006 i_DONE  in  1  one-cycle strobe; i_DATA is valid on this cycle.
REQ-007 o_CMD_VALID  out  1  command pending; held high until acknowledged.
REQ-008 o_CMD_WR  out  1  pending command type: 1 = write, 0 = read.
REQ-009 o_ADDR  out  ADDR_W  pending command address.
REQ-010 o_WDATA  out  DATA_W  pending write data; 0 for reads.
REQ-011 i_CMD_ACK  in  1  consumer accepts the pending command.
REQ-012 o_ERR  out  1  one-cycle pulse when a malformed line is terminated.
REQ-013 o_OVERRUN  out  1  one-cycle pulse when a byte is dropped while a command is pending.
REQ-014 o_ERR_CNT  out  8  saturating count of o_ERR pulses.

Function
REQ-015 Accepted line grammar: "W<sp>hex<sp>hex<CR>" or "R<sp>hex<CR>". Command letters are case-insensitive. Hex digits are 0-9, A-F, a-f. Exactly one space (0x20) between fields. Line terminator is CR (0x0D).
REQ-016 Each field SHALL contain 1..N digits. Each digit is accumulated as field = {field[W-5:0], nibble}. Fields shorter than N digits are zero-extended.
REQ-017 The block SHALL act only on cycles where i_DONE=1; i_DATA is ignored otherwise.
REQ-018 States SHALL be IDLE, SP1, ADDR, DATA, ISSUE, FLUSH.
REQ-019 IDLE:
  - 'R'/'r' -> SP1 with op=read.
  - 'W'/'w' -> SP1 with op=write.
  - CR, LF (0x0A) or space -> stay in IDLE, no error.
  - any other byte -> FLUSH.
REQ-020 SP1:
  - space -> ADDR; clear the address accumulator and the digit count.
  - CR -> o_ERR, then IDLE.
  - any other byte -> FLUSH.
REQ-021 ADDR:
  - hex digit with count < ADDR_W/4 -> accumulate.
  - hex digit when count = ADDR_W/4 -> FLUSH.
  - space with count>0 and op=write -> DATA; clear the data accumulator and the digit count.
  - CR with count>0 and op=read -> ISSUE.
  - CR in any other case -> o_ERR, then IDLE.
  - any other byte or condition -> FLUSH.
REQ-022 DATA:
  - hex digit with count < DATA_W/4 -> accumulate.
  - hex digit when count = DATA_W/4 -> FLUSH.
  - CR with count>0 -> ISSUE.
  - CR with count=0 -> o_ERR, then IDLE.
  - any other byte -> FLUSH.
REQ-023 FLUSH: discard bytes until CR; on CR pulse o_ERR and go to IDLE.
REQ-024 o_ERR SHALL be high exactly the cycle after the i_DONE of the terminating CR.
REQ-025 On entry to ISSUE, o_CMD_VALID, o_CMD_WR, o_ADDR and o_WDATA SHALL be registered. They assert the cycle after the CR strobe and stay stable while o_CMD_VALID=1.
REQ-026 ISSUE: when o_CMD_VALID=1 and i_CMD_ACK=1 in the same cycle, o_CMD_VALID SHALL deassert the next cycle and the state returns to IDLE.
REQ-027 i_CMD_ACK while o_CMD_VALID=0 SHALL be ignored.
REQ-028 i_DONE in ISSUE: the byte is dropped and o_OVERRUN pulses the next cycle.
REQ-029 i_DONE and i_CMD_ACK in the same ISSUE cycle: the byte is dropped with o_OVERRUN, the command is consumed, and the state goes to IDLE.
REQ-030 o_ERR_CNT SHALL increment on each o_ERR pulse and hold at 255.

Reset
REQ-031 While HRST=1 at a clock edge:
  - state <= IDLE.
  - o_CMD_VALID, o_CMD_WR, o_ERR, o_OVERRUN <= 0.
  - o_ADDR, o_WDATA, o_ERR_CNT <= 0.
  - accumulators and digit counts <= 0.
REQ-032 HRST SHALL take priority over i_DONE and i_CMD_ACK in the same cycle. Reset mid-line or mid-ISSUE discards the partial or pending command with no o_ERR.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
  - Bytes "W 12 abCD\r", i_CMD_ACK tied high -> one cycle of o_CMD_VALID=1, o_CMD_WR=1, o_ADDR=0x0012, o_WDATA=0xABCD; no o_ERR.
  - Bytes "r FFFF\r", i_CMD_ACK held low 20 cycles, then "R 1\r" sent -> o_CMD_VALID stays high with o_ADDR=0xFFFF, o_CMD_WR=0; 4 o_OVERRUN pulses; after ACK, state IDLE and no second command.
  - Bytes "W 12345 1\r" -> FLUSH; single o_ERR one cycle after the CR strobe; o_ERR_CNT=1; no o_CMD_VALID.
  - Bytes "R\r", "W 10\r", "X\r", "R 1 2\r" -> four o_ERR pulses, o_ERR_CNT=4; a following "R 7\r" yields o_ADDR=0x0007.
  - HRST asserted after "W 12 3" -> all outputs 0; a following "R A\r" yields o_ADDR=0x000A with no o_ERR.
  - 300 bad lines -> o_ERR_CNT saturates at 255.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser: turns "W addr data<CR>" / "R addr<CR>" lines from a
// UART receiver into a held command with a valid/ack handshake.
//
// state  | meaning
// IDLE   | waiting for a command letter; stray CR/LF/space skipped
// SP1    | command letter seen, expecting the separating space
// ADDR   | accumulating address hex digits
// DATA   | accumulating write-data hex digits
// ISSUE  | command held on the outputs until acknowledged
// FLUSH  | malformed line, discarding bytes until CR
module uart_cmd_parser #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              MCLK,
  input  logic              HRST,
  input  logic [7:0]        i_DATA,
  input  logic              i_DONE,
  output logic              o_CMD_VALID,
  output logic              o_CMD_WR,
  output logic [ADDR_W-1:0] o_ADDR,
  output logic [DATA_W-1:0] o_WDATA,
  input  logic              i_CMD_ACK,
  output logic              o_ERR,
  output logic              o_OVERRUN,
  output logic [7:0]        o_ERR_CNT
);

  localparam int ADDR_DIG = ADDR_W / 4;
  localparam int DATA_DIG = DATA_W / 4;
  localparam int MAX_DIG  = (ADDR_DIG > DATA_DIG) ? ADDR_DIG : DATA_DIG;
  localparam int CNT_W    = $clog2(MAX_DIG + 1);
  localparam logic [CNT_W-1:0] ADDR_MAX = CNT_W'(ADDR_DIG);
  localparam logic [CNT_W-1:0] DATA_MAX = CNT_W'(DATA_DIG);
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE, S_SP1, S_ADDR, S_DATA, S_ISSUE, S_FLUSH
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_acc, addr_acc_nxt;
  logic [DATA_W-1:0]   data_acc, data_acc_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                op_wr, op_wr_nxt;
  logic                valid_nxt, wr_nxt, err_nxt, ovr_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic                is_hex, is_cr, is_sp, is_lf, is_r, is_w;
  logic [3:0]          nib;

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (i_DATA >= 8'h30 && i_DATA <= 8'h39) begin
      is_hex = 1'b1;
      nib    = i_DATA[3:0];
    end else if ((i_DATA >= 8'h41 && i_DATA <= 8'h46) ||
                 (i_DATA >= 8'h61 && i_DATA <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = i_DATA[3:0] + 4'd9;
    end
    is_cr = (i_DATA == CH_CR);
    is_lf = (i_DATA == CH_LF);
    is_sp = (i_DATA == CH_SP);
    is_r  = (i_DATA == 8'h52) || (i_DATA == 8'h72);
    is_w  = (i_DATA == 8'h57) || (i_DATA == 8'h77);
  end

  always_comb begin
    state_nxt    = state;
    addr_acc_nxt = addr_acc;
    data_acc_nxt = data_acc;
    cnt_nxt      = cnt;
    op_wr_nxt    = op_wr;
    valid_nxt    = o_CMD_VALID;
    wr_nxt       = o_CMD_WR;
    addr_nxt     = o_ADDR;
    wdata_nxt    = o_WDATA;
    err_nxt      = 1'b0;
    ovr_nxt      = 1'b0;
    case (state)
      S_IDLE: if (i_DONE) begin
        if (is_r) begin
          state_nxt = S_SP1;
          op_wr_nxt = 1'b0;
        end else if (is_w) begin
          state_nxt = S_SP1;
          op_wr_nxt = 1'b1;
        end else if (!(is_cr || is_lf || is_sp)) begin
          state_nxt = S_FLUSH;
        end
      end
      S_SP1: if (i_DONE) begin
        if (is_sp) begin
          state_nxt    = S_ADDR;
          addr_acc_nxt = '0;
          cnt_nxt      = '0;
        end else if (is_cr) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_FLUSH;
        end
      end
      S_ADDR: if (i_DONE) begin
        if (is_hex) begin
          if (cnt < ADDR_MAX) begin
            addr_acc_nxt = (addr_acc << 4) | ADDR_W'(nib);
            cnt_nxt      = cnt + CNT_W'(1);
          end else begin
            state_nxt = S_FLUSH;
          end
        end else if (is_sp && cnt != '0 && op_wr) begin
          state_nxt    = S_DATA;
          data_acc_nxt = '0;
          cnt_nxt      = '0;
        end else if (is_cr && cnt != '0 && !op_wr) begin
          state_nxt = S_ISSUE;
          valid_nxt = 1'b1;
          wr_nxt    = 1'b0;
          addr_nxt  = addr_acc;
          wdata_nxt = '0;
        end else if (is_cr) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_FLUSH;
        end
      end
      S_DATA: if (i_DONE) begin
        if (is_hex) begin
          if (cnt < DATA_MAX) begin
            data_acc_nxt = (data_acc << 4) | DATA_W'(nib);
            cnt_nxt      = cnt + CNT_W'(1);
          end else begin
            state_nxt = S_FLUSH;
          end
        end else if (is_cr && cnt != '0) begin
          state_nxt = S_ISSUE;
          valid_nxt = 1'b1;
          wr_nxt    = 1'b1;
          addr_nxt  = addr_acc;
          wdata_nxt = data_acc;
        end else if (is_cr) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_FLUSH;
        end
      end
      S_ISSUE: begin
        // Bytes arriving while a command is held have nowhere to go.
        if (i_DONE) ovr_nxt = 1'b1;
        if (o_CMD_VALID && i_CMD_ACK) begin
          valid_nxt = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      S_FLUSH: if (i_DONE && is_cr) begin
        err_nxt   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (HRST) begin
      state       <= S_IDLE;
      addr_acc    <= '0;
      data_acc    <= '0;
      cnt         <= '0;
      op_wr       <= 1'b0;
      o_CMD_VALID <= 1'b0;
      o_CMD_WR    <= 1'b0;
      o_ADDR      <= '0;
      o_WDATA     <= '0;
      o_ERR       <= 1'b0;
      o_OVERRUN   <= 1'b0;
      o_ERR_CNT   <= 8'd0;
    end else begin
      state       <= state_nxt;
      addr_acc    <= addr_acc_nxt;
      data_acc    <= data_acc_nxt;
      cnt         <= cnt_nxt;
      op_wr       <= op_wr_nxt;
      o_CMD_VALID <= valid_nxt;
      o_CMD_WR    <= wr_nxt;
      o_ADDR      <= addr_nxt;
      o_WDATA     <= wdata_nxt;
      o_ERR       <= err_nxt;
      o_OVERRUN   <= ovr_nxt;
      if (err_nxt && o_ERR_CNT != 8'hFF) o_ERR_CNT <= o_ERR_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: whole-line reference parser checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_cmd_parser;

  logic        MCLK = 1'b0;
  logic        HRST;
  logic [7:0]  i_DATA;
  logic        i_DONE;
  logic        o_CMD_VALID, o_CMD_WR;
  logic [15:0] o_ADDR, o_WDATA;
  logic        i_CMD_ACK;
  logic        o_ERR, o_OVERRUN;
  logic [7:0]  o_ERR_CNT;

  uart_cmd_parser #(.ADDR_W(16), .DATA_W(16)) dut (
    .MCLK(MCLK), .HRST(HRST), .i_DATA(i_DATA), .i_DONE(i_DONE),
    .o_CMD_VALID(o_CMD_VALID), .o_CMD_WR(o_CMD_WR), .o_ADDR(o_ADDR),
    .o_WDATA(o_WDATA), .i_CMD_ACK(i_CMD_ACK), .o_ERR(o_ERR),
    .o_OVERRUN(o_OVERRUN), .o_ERR_CNT(o_ERR_CNT)
  );

  always #5 MCLK = ~MCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffer the line, judge it as a whole when CR arrives.
  logic [7:0]  line_q[$];
  bit          started = 0;
  logic        m_valid = 0, m_wr = 0, m_err = 0, m_ovr = 0;
  logic [15:0] m_addr = 0, m_wdata = 0;
  logic [7:0]  m_cnt = 0;

  function automatic bit is_hex_c(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic int hex_val(input logic [7:0] c);
    if (c <= 8'h39) return int'(c) - 48;
    if (c <= 8'h46) return int'(c) - 55;
    return int'(c) - 87;
  endfunction

  function automatic bit parse_line(output bit wr, output int addr, output int data);
    int i, n, cnt;
    n = line_q.size(); wr = 0; addr = 0; data = 0;
    if (n < 3) return 0;
    if (line_q[0] == 8'h52 || line_q[0] == 8'h72) wr = 0;
    else if (line_q[0] == 8'h57 || line_q[0] == 8'h77) wr = 1;
    else return 0;
    if (line_q[1] != 8'h20) return 0;
    i = 2; cnt = 0;
    while (i < n && is_hex_c(line_q[i])) begin
      addr = addr * 16 + hex_val(line_q[i]); cnt++; i++;
    end
    if (cnt < 1 || cnt > 4) return 0;
    if (wr) begin
      if (i >= n || line_q[i] != 8'h20) return 0;
      i++; cnt = 0;
      while (i < n && is_hex_c(line_q[i])) begin
        data = data * 16 + hex_val(line_q[i]); cnt++; i++;
      end
      if (cnt < 1 || cnt > 4) return 0;
    end
    return i == n;
  endfunction

  always @(posedge MCLK) begin
    bit w; int a, d;
    if (HRST) begin
      m_valid = 0; m_wr = 0; m_err = 0; m_ovr = 0;
      m_addr = 0; m_wdata = 0; m_cnt = 0;
      line_q.delete();
      started = 1;
    end else begin
      m_err = 0; m_ovr = 0;
      if (m_valid) begin
        if (i_DONE) m_ovr = 1;
        if (i_CMD_ACK) m_valid = 0;
      end else if (i_DONE) begin
        if (line_q.size() == 0 && (i_DATA == 8'h0D || i_DATA == 8'h0A || i_DATA == 8'h20)) begin
          // blank-line filler between commands
        end else if (i_DATA == 8'h0D) begin
          if (parse_line(w, a, d)) begin
            m_valid = 1; m_wr = w; m_addr = a[15:0]; m_wdata = w ? d[15:0] : 16'h0;
          end else begin
            m_err = 1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
          end
          line_q.delete();
        end else begin
          line_q.push_back(i_DATA);
        end
      end
    end
  end

  // Per-cycle compare plus event counters for the directed checks.
  int          valid_rises = 0, err_pulses = 0, ovr_pulses = 0;
  logic        prev_valid = 0, cap_wr = 0;
  logic [15:0] cap_addr = 0, cap_wdata = 0;

  always @(negedge MCLK) begin
    if (started) begin
      chk("cmd_valid", 32'(o_CMD_VALID), 32'(m_valid));
      chk("err", 32'(o_ERR), 32'(m_err));
      chk("overrun", 32'(o_OVERRUN), 32'(m_ovr));
      chk("err_cnt", 32'(o_ERR_CNT), 32'(m_cnt));
      if (m_valid) begin
        chk("cmd_wr", 32'(o_CMD_WR), 32'(m_wr));
        chk("addr", 32'(o_ADDR), 32'(m_addr));
        chk("wdata", 32'(o_WDATA), 32'(m_wdata));
      end
      if (o_CMD_VALID && !prev_valid) begin
        valid_rises++;
        cap_wr = o_CMD_WR; cap_addr = o_ADDR; cap_wdata = o_WDATA;
      end
      if (o_ERR) err_pulses++;
      if (o_OVERRUN) ovr_pulses++;
      prev_valid = o_CMD_VALID;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge MCLK);
    i_DATA = b; i_DONE = 1'b1;
    @(negedge MCLK);
    i_DONE = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_line(input string s);
    send_str(s);
    send_byte(8'h0D);
  endtask

  task automatic clear_counts();
    @(posedge MCLK);
    valid_rises = 0; err_pulses = 0; ovr_pulses = 0;
  endtask

  task automatic apply_reset();
    @(negedge MCLK);
    HRST = 1'b1;
    repeat (2) @(negedge MCLK);
    HRST = 1'b0;
    clear_counts();
    @(negedge MCLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_CMD_VALID), 32'd0);
    chk({tag, "_wr"}, 32'(o_CMD_WR), 32'd0);
    chk({tag, "_addr"}, 32'(o_ADDR), 32'd0);
    chk({tag, "_wdata"}, 32'(o_WDATA), 32'd0);
    chk({tag, "_err"}, 32'(o_ERR), 32'd0);
    chk({tag, "_ovr"}, 32'(o_OVERRUN), 32'd0);
    chk({tag, "_errcnt"}, 32'(o_ERR_CNT), 32'd0);
  endtask

  initial begin
    HRST = 1'b1; i_DATA = 8'h00; i_DONE = 1'b0; i_CMD_ACK = 1'b0;
    repeat (3) @(negedge MCLK);
    chk_all_zero("reset");
    HRST = 1'b0;
    clear_counts();

    // Write with ack tied high: exactly one valid cycle.
    i_CMD_ACK = 1'b1;
    send_line("W 12 abCD");
    repeat (3) @(negedge MCLK);
    chk("s1_rises", 32'(valid_rises), 32'd1);
    chk("s1_wr", 32'(cap_wr), 32'd1);
    chk("s1_addr", 32'(cap_addr), 32'h0012);
    chk("s1_wdata", 32'(cap_wdata), 32'hABCD);
    chk("s1_errs", 32'(err_pulses), 32'd0);

    // Read held without ack, extra line arrives as overruns.
    apply_reset();
    i_CMD_ACK = 1'b0;
    send_line("r FFFF");
    repeat (20) @(negedge MCLK);
    send_line("R 1");
    repeat (2) @(negedge MCLK);
    chk("s2_valid", 32'(o_CMD_VALID), 32'd1);
    chk("s2_addr", 32'(o_ADDR), 32'hFFFF);
    chk("s2_wr", 32'(o_CMD_WR), 32'd0);
    chk("s2_ovr", 32'(ovr_pulses), 32'd4);
    i_CMD_ACK = 1'b1;
    @(negedge MCLK);
    i_CMD_ACK = 1'b0;
    chk("s2_valid_after_ack", 32'(o_CMD_VALID), 32'd0);
    repeat (10) @(negedge MCLK);
    chk("s2_rises", 32'(valid_rises), 32'd1);

    // Address overflow: one error exactly one cycle after the CR strobe.
    apply_reset();
    i_CMD_ACK = 1'b1;
    send_line("W 12345 1");
    chk("s3_err_timing", 32'(o_ERR), 32'd1);
    repeat (3) @(negedge MCLK);
    chk("s3_errs", 32'(err_pulses), 32'd1);
    chk("s3_errcnt", 32'(o_ERR_CNT), 32'd1);
    chk("s3_rises", 32'(valid_rises), 32'd0);

    // Four different malformed lines, then a good read.
    apply_reset();
    send_line("R");
    send_line("W 10");
    send_line("X");
    send_line("R 1 2");
    repeat (3) @(negedge MCLK);
    chk("s4_errs", 32'(err_pulses), 32'd4);
    chk("s4_errcnt", 32'(o_ERR_CNT), 32'd4);
    send_line("R 7");
    repeat (3) @(negedge MCLK);
    chk("s4_rises", 32'(valid_rises), 32'd1);
    chk("s4_addr", 32'(cap_addr), 32'h0007);
    chk("s4_wr", 32'(cap_wr), 32'd0);

    // Reset mid-line discards the partial command silently.
    apply_reset();
    send_str("W 12 3");
    @(negedge MCLK);
    HRST = 1'b1;
    @(negedge MCLK);
    chk_all_zero("s5_reset");
    HRST = 1'b0;
    clear_counts();
    send_line("R A");
    repeat (3) @(negedge MCLK);
    chk("s5_rises", 32'(valid_rises), 32'd1);
    chk("s5_addr", 32'(cap_addr), 32'h000A);
    chk("s5_errs", 32'(err_pulses), 32'd0);

    // Reset wins over ack and a byte while a command is pending.
    i_CMD_ACK = 1'b0;
    send_line("R 5");
    @(negedge MCLK);
    chk("s6_pending", 32'(o_CMD_VALID), 32'd1);
    HRST = 1'b1; i_CMD_ACK = 1'b1; i_DATA = 8'h0D; i_DONE = 1'b1;
    @(negedge MCLK);
    HRST = 1'b0; i_CMD_ACK = 1'b0; i_DONE = 1'b0;
    chk("s6_valid", 32'(o_CMD_VALID), 32'd0);
    chk("s6_ovr", 32'(o_OVERRUN), 32'd0);
    chk("s6_err", 32'(o_ERR), 32'd0);

    // Error counter saturation.
    apply_reset();
    i_CMD_ACK = 1'b1;
    repeat (300) send_line("X");
    repeat (3) @(negedge MCLK);
    chk("s7_errcnt", 32'(o_ERR_CNT), 32'd255);
    chk("s7_errs", 32'(err_pulses), 32'd300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
